trivium_decrypt: RTL and testbench
==================================

// Module: trivium_decrypt
// PURPOSE
//  Receive side of the Trivium link: regenerates the keystream from KEY/IV and XORs it onto an
//  incoming ciphertext word stream to recover plaintext. Counterpart of ENCRIPT, sharing its
//  80-bit KEY/IV format and cipher state. Streams W bits/clock with valid/ready on both sides.
//  Sits between the link receiver (ciphertext in) and the consumer (plaintext out).
// PARAMETERS
//  W        8     keystream/data bits per clock; legal values 1,2,4,8,16,32,64 (must divide 1152)
//  INIT_RND 1152  warm-up rounds before first keystream bit; INIT_CYC = INIT_RND/W
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-low; all state cleared while 0
//  start     in   1   1-cycle pulse: sample key/iv, (re)load state, begin warm-up
//  key       in   80  cipher key, key[79] = K1
//  iv        in   80  IV, iv[79] = IV1
//  ct_valid  in   1   ciphertext word valid
//  ct_data   in   W   ciphertext word; bit [W-1] is first in time
//  ct_last   in   1   final word of message
//  ct_ready  out  1   decryptor accepts ct word this cycle
//  pt_valid  out  1   plaintext word valid
//  pt_data   out  W   plaintext = ct_data ^ keystream
//  pt_last   out  1   copy of ct_last for this word
//  pt_ready  in   1   consumer accepts pt word
//  busy      out  1   state != IDLE
//  init_done out  1   1 in RUN (keystream available)
// BEHAVIOUR
//  Reset: state=IDLE; s[1:288]=0; round counter=0; ct_ready=0, pt_valid=0, pt_data=0,
//   pt_last=0, busy=0, init_done=0.
//  Load (on start): s1..s80=key[79:0] (K1 first), s81..s93=0; s94..s173=iv[79:0], s174..s177=0;
//   s178..s285=0; s286..s288=1. Counter cleared.
//  Round: t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3;
//   t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69;
//   s1..93<=(t3,s1..s92); s94..177<=(t1,s94..s176); s178..288<=(t2,s178..s287).
//   W rounds unrolled per clock; z of round 1 -> keystream bit [W-1].
//  FSM: IDLE --start--> INIT; INIT: W rounds/clock, discard z; after INIT_CYC cycles -> RUN.
//   RUN: word accepted when ct_valid&ct_ready -> pt_data<=ct_data^ks, pt_last<=ct_last,
//   pt_valid<=1, state advances W rounds. Keystream advances ONLY on accepted words.
//   Handshake of the pt word with pt_last=1 -> IDLE (state regs kept; next start reloads).
//  ct_ready = (state==RUN) & (~pt_valid | pt_ready): single output register, full throughput,
//   1-cycle latency ct accept -> pt_valid. pt_valid/pt_data/pt_last held stable while pt_valid&~pt_ready.
//  pt_valid clears on pt handshake with no new accept in the same cycle.
//  start in INIT or RUN: abort; reload from new key/iv, restart INIT; pending pt word dropped
//   (pt_valid<=0). start has priority over a simultaneous ct accept.
//  ct_valid outside RUN: ignored, ct_ready=0. Reset mid-message: immediate return to reset values.
//  First plaintext word available INIT_CYC+1 cycles after start if ct_valid held high.
// STRUCTURE
//  trivium_pkg: STATE_W=288, KEY_W=80, IV_W=80, INIT_RND=1152, tap index constants
//   (66,93,91,92,171,162,177,175,176,264,243,288,286,287,69), state_t typedef, load function.
//  Sub-module trivium_round_w (combinational, param W): state_in -> state_out, ks[W-1:0];
//   shared with ENCRIPT. Top holds FSM, counter (clog2(INIT_CYC+1) bits), state and output regs.
// TESTING
//  1 Reset low mid-RUN with pt_valid=1 -> all outputs 0 same cycle, busy=0, ct_ready=0.
//  2 key=80'h0, iv=80'h8000_0000_0000_0000_0000, start, ct_data=8'h00 x64 -> pt stream equals
//    ENCRIPT OUT[511:0] MSB-first; first pt_valid exactly INIT_CYC+1=145 cycles after start (W=8).
//  3 Round trip: plaintext 64 bytes 0x00..0x3F encrypted via ENCRIPT same key/iv -> decrypts to
//    0x00..0x3F, pt_last on byte 0x3F, then busy=0.
//  4 Random pt_ready/ct_valid stalls (50%) -> identical pt stream to test 3; pt_data stable during stall.
//  5 start pulsed after 10 words with new iv -> pt_valid drops, 144 INIT cycles, stream matches new-iv model.
//  6 ct_valid=1 during INIT -> ct_ready=0, no words consumed, keystream offset unchanged.

Source files
------------

// File: rtl/trivium_pkg.sv
// Shared Trivium definitions: sizes, tap positions, FSM encoding and the key/IV load.
package trivium_pkg;

  localparam int STATE_W  = 288;
  localparam int KEY_W    = 80;
  localparam int IV_W     = 80;
  localparam int INIT_RND = 1152;

  // Tap positions, 1-based to match the usual s1..s288 numbering
  localparam int T1_A  = 66;
  localparam int T1_B  = 93;
  localparam int T1_N0 = 91;
  localparam int T1_N1 = 92;
  localparam int T1_C  = 171;
  localparam int T2_A  = 162;
  localparam int T2_B  = 177;
  localparam int T2_N0 = 175;
  localparam int T2_N1 = 176;
  localparam int T2_C  = 264;
  localparam int T3_A  = 243;
  localparam int T3_B  = 288;
  localparam int T3_N0 = 286;
  localparam int T3_N1 = 287;
  localparam int T3_C  = 69;

  // Ascending range so s[i] is literally s_i; s[1] is the MSB of the vector
  typedef logic [1:STATE_W] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } fsm_t;

  function automatic state_t trivium_load(input logic [KEY_W-1:0] key,
                                          input logic [IV_W-1:0]  iv);
    state_t s;
    s          = '0;
    s[1:80]    = key;
    s[94:173]  = iv;
    s[286:288] = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_round_w.sv
// W unrolled Trivium rounds; keystream bit of the first round lands in ks_o[W-1].
module trivium_round_w
  import trivium_pkg::*;
#(
  parameter int W = 8
) (
  input  state_t         state_i,
  output state_t         state_o,
  output logic [W-1:0]   ks_o
);

  always_comb begin
    state_t s;
    logic   t1, t2, t3;
    s    = state_i;
    ks_o = '0;
    t1   = 1'b0;
    t2   = 1'b0;
    t3   = 1'b0;
    for (int r = 0; r < W; r++) begin
      t1 = s[T1_A] ^ s[T1_B];
      t2 = s[T2_A] ^ s[T2_B];
      t3 = s[T3_A] ^ s[T3_B];
      ks_o[W-1-r] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[T1_N0] & s[T1_N1]) ^ s[T1_C];
      t2 = t2 ^ (s[T2_N0] & s[T2_N1]) ^ s[T2_C];
      t3 = t3 ^ (s[T3_N0] & s[T3_N1]) ^ s[T3_C];
      s  = {t3, s[1:92], t1, s[94:176], t2, s[178:287]};
    end
    state_o = s;
  end

endmodule

// File: rtl/trivium_decrypt.sv
// Trivium receive path: warm up from KEY/IV, then XOR keystream onto accepted ciphertext words.
module trivium_decrypt
  import trivium_pkg::*;
#(
  parameter int W        = 8,
  parameter int INIT_RND = trivium_pkg::INIT_RND
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  input  logic             ct_valid,
  input  logic [W-1:0]     ct_data,
  input  logic             ct_last,
  output logic             ct_ready,
  output logic             pt_valid,
  output logic [W-1:0]     pt_data,
  output logic             pt_last,
  input  logic             pt_ready,
  output logic             busy,
  output logic             init_done
);

  localparam int INIT_CYC = INIT_RND / W;
  localparam int CNT_W    = $clog2(INIT_CYC + 1);

  fsm_t             fsm_q, fsm_d;
  state_t           s_q, s_d, s_rnd;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pt_valid_q, pt_valid_d;
  logic [W-1:0]     pt_data_q, pt_data_d;
  logic             pt_last_q, pt_last_d;
  logic [W-1:0]     ks;
  logic             ct_hs, pt_hs;

  trivium_round_w #(.W(W)) u_round (
    .state_i (s_q),
    .state_o (s_rnd),
    .ks_o    (ks)
  );

  assign ct_ready  = (fsm_q == ST_RUN) & (~pt_valid_q | pt_ready);
  assign ct_hs     = ct_valid & ct_ready;
  assign pt_hs     = pt_valid_q & pt_ready;
  assign pt_valid  = pt_valid_q;
  assign pt_data   = pt_data_q;
  assign pt_last   = pt_last_q;
  assign busy      = (fsm_q != ST_IDLE);
  assign init_done = (fsm_q == ST_RUN);

  always_comb begin
    fsm_d      = fsm_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    pt_valid_d = pt_valid_q;
    pt_data_d  = pt_data_q;
    pt_last_d  = pt_last_q;

    if (pt_hs) pt_valid_d = 1'b0;

    if (start) begin
      // Restart wins over everything, including an accept in the same cycle
      fsm_d      = ST_INIT;
      s_d        = trivium_load(key, iv);
      cnt_d      = '0;
      pt_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        ST_INIT: begin
          s_d   = s_rnd;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(INIT_CYC - 1)) fsm_d = ST_RUN;
        end
        ST_RUN: begin
          // Keystream only moves when a ciphertext word is actually consumed
          if (ct_hs) begin
            s_d        = s_rnd;
            pt_valid_d = 1'b1;
            pt_data_d  = ct_data ^ ks;
            pt_last_d  = ct_last;
          end
          if (pt_hs && pt_last_q) fsm_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q      <= ST_IDLE;
      s_q        <= '0;
      cnt_q      <= '0;
      pt_valid_q <= 1'b0;
      pt_data_q  <= '0;
      pt_last_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      pt_valid_q <= pt_valid_d;
      pt_data_q  <= pt_data_d;
      pt_last_q  <= pt_last_d;
    end
  end

endmodule

// File: tb/tb_trivium_decrypt.sv
// Directed bench for trivium_decrypt with a bit-serial reference keystream generator.
module tb_trivium_decrypt;

  localparam int W  = 8;
  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [79:0] key = '0;
  logic [79:0] iv = '0;
  logic        ct_valid = 1'b0;
  logic [7:0]  ct_data = '0;
  logic        ct_last = 1'b0;
  logic        ct_ready;
  logic        pt_valid;
  logic [7:0]  pt_data;
  logic        pt_last;
  logic        pt_ready = 1'b0;
  logic        busy;
  logic        init_done;

  trivium_decrypt #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .iv        (iv),
    .ct_valid  (ct_valid),
    .ct_data   (ct_data),
    .ct_last   (ct_last),
    .ct_ready  (ct_ready),
    .pt_valid  (pt_valid),
    .pt_data   (pt_data),
    .pt_last   (pt_last),
    .pt_ready  (pt_ready),
    .busy      (busy),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: one round per call, straight from the s1..s288 description
  bit [1:288] ms;

  function automatic bit m_step();
    bit t1, t2, t3, z;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i > 1; i--) ms[i] = ms[i-1];
    ms[1]   = t3;
    ms[94]  = t1;
    ms[178] = t2;
    return z;
  endfunction

  function automatic logic [7:0] m_byte();
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) b[i] = m_step();
    return b;
  endfunction

  logic [7:0] ct_w [NW];
  logic [7:0] exp_w[NW];

  // zero_ct: ciphertext all zero so plaintext equals raw keystream;
  // otherwise plaintext is 0x00..0x3F and ciphertext is pre-encrypted by the model
  task automatic prep(input logic [79:0] k, input logic [79:0] v, input bit zero_ct);
    logic [7:0] ks;
    ms = '0;
    for (int i = 1; i <= 80; i++) ms[i] = k[80-i];
    for (int i = 1; i <= 80; i++) ms[93+i] = v[80-i];
    ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
    for (int i = 0; i < 1152; i++) void'(m_step());
    for (int i = 0; i < NW; i++) begin
      ks = m_byte();
      if (zero_ct) begin
        ct_w[i]  = 8'h00;
        exp_w[i] = ks;
      end else begin
        ct_w[i]  = 8'(i) ^ ks;
        exp_w[i] = 8'(i);
      end
    end
  endtask

  task automatic do_start(input logic [79:0] k, input logic [79:0] v, input bit cv);
    @(posedge clk); #1;
    key = k; iv = v; start = 1'b1; ct_valid = cv; ct_data = 8'h00;
    @(posedge clk); #1;
    start = 1'b0; ct_valid = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit stall, input bit last_en, input bit chk_lat);
    int ii, oi, first;
    bit held_v, rdy_early;
    logic [7:0] held;
    ii = 0; oi = 0; first = -1; held_v = 0; rdy_early = 0; held = '0;
    for (int k = 1; k <= 4000 && oi < n; k++) begin
      @(posedge clk); #1;
      ct_valid = (ii < n) && (!stall || $urandom_range(0, 1) == 1);
      if (ct_valid) ct_data = ct_w[ii];
      else          ct_data = 8'h00;
      ct_last  = last_en && (ii == n - 1);
      pt_ready = !stall || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (held_v) begin
        chk("hold_valid", 64'(pt_valid), 64'd1);
        chk("hold_data", 64'(pt_data), 64'(held));
      end
      if (pt_valid && first < 0) first = k;
      if (!init_done && ct_ready) rdy_early = 1;
      if (pt_valid && pt_ready) begin
        chk($sformatf("pt_data[%0d]", oi), 64'(pt_data), 64'(exp_w[oi]));
        chk($sformatf("pt_last[%0d]", oi), 64'(pt_last), 64'(last_en && oi == n - 1));
        oi++;
      end
      held_v = pt_valid && !pt_ready;
      held   = pt_data;
      if (ct_valid && ct_ready) ii++;
    end
    if (oi < n) chk("timeout_words", 64'(oi), 64'(n));
    if (chk_lat) begin
      chk("first_pt_latency", 64'(first), 64'd145);
      chk("ct_ready_in_init", 64'(rdy_early), 64'd0);
    end
  endtask

  task automatic idle_chk(input string tag);
    @(posedge clk); #1;
    ct_valid = 1'b0; ct_last = 1'b0; pt_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pt_valid"}, 64'(pt_valid), 64'd0);
    chk({tag, "_ct_ready"}, 64'(ct_ready), 64'd0);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_ct_ready"}, 64'(ct_ready), 64'd0);
    chk({tag, "_pt_valid"}, 64'(pt_valid), 64'd0);
    chk({tag, "_pt_data"}, 64'(pt_data), 64'd0);
    chk({tag, "_pt_last"}, 64'(pt_last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
  endtask

  localparam logic [79:0] K0  = 80'h0;
  localparam logic [79:0] IV0 = 80'h8000_0000_0000_0000_0000;
  localparam logic [79:0] K3  = 80'h0123_4567_89AB_CDEF_FEDC;
  localparam logic [79:0] IV3 = 80'hA5A5_0F0F_3C3C_1234_5678;
  localparam logic [79:0] IV5 = 80'h0000_1111_2222_3333_4444;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_chk("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    // raw keystream, key 0 / iv MSB set; ct_valid held high through warm-up
    prep(K0, IV0, 1'b1);
    do_start(K0, IV0, 1'b1);
    run_stream(NW, 1'b0, 1'b1, 1'b1);
    idle_chk("ks_end");

    // round trip, full throughput
    prep(K3, IV3, 1'b0);
    do_start(K3, IV3, 1'b0);
    run_stream(NW, 1'b0, 1'b1, 1'b1);
    idle_chk("rt_end");

    // same message under random stalls on both sides
    do_start(K3, IV3, 1'b0);
    run_stream(NW, 1'b1, 1'b1, 1'b0);
    idle_chk("stall_end");

    // abort after 10 words with one word pending, restart on a new iv
    do_start(K3, IV3, 1'b0);
    run_stream(10, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    ct_valid = 1'b1; ct_data = ct_w[10]; pt_ready = 1'b0;
    @(posedge clk); #1;
    ct_valid = 1'b0;
    @(negedge clk);
    chk("pending_valid", 64'(pt_valid), 64'd1);
    chk("pending_data", 64'(pt_data), 64'h0A);
    prep(K3, IV5, 1'b0);
    do_start(K3, IV5, 1'b1);
    chk("abort_pt_valid", 64'(pt_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_init_done", 64'(init_done), 64'd0);
    run_stream(NW, 1'b0, 1'b1, 1'b1);
    idle_chk("newiv_end");

    // reset mid-message while a word is held
    prep(K3, IV3, 1'b0);
    do_start(K3, IV3, 1'b0);
    run_stream(3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    ct_valid = 1'b1; ct_data = ct_w[3]; pt_ready = 1'b0;
    @(posedge clk); #1;
    ct_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_valid", 64'(pt_valid), 64'd1);
    chk("midrst_pre_data", 64'(pt_data), 64'h03);
    reset = 1'b0;
    #1;
    reset_chk("midrst");
    @(posedge clk); #1;
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
